sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
Front-end stage that feeds the security FSM's sensor inputs (arm, intrusion, confirm on bits 0/1/2).
- Synchronizes each raw asynchronous sensor line, debounces it, and produces clean levels plus one-cycle edge pulses.
- Also watches for rejected glitches and raises a sticky tamper flag when too many occur within a time window.
- Outputs lvl_out[2:0] drive the FSM's ui_in[2:0] directly.

Parameters:
- NUM_CH, 3, number of sensor channels (bit 0 arm, bit 1 intrusion, bit 2 confirm).
- DEBOUNCE_CYCLES, 4, cycles a synchronized level must persist before being accepted; minimum 2.
- WINDOW_CYCLES, 1024, length of the tamper observation window in clocks; minimum 2.
- TAMPER_LIMIT, 8, rejected-glitch count within one window that sets tamper; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- raw_in  input  NUM_CH  asynchronous raw sensor lines.
- clr_tamper  input  1  synchronous clear of tamper flag and glitch count.
- lvl_out  output  NUM_CH  debounced, registered sensor levels.
- rise_out  output  NUM_CH  one-cycle pulse when lvl_out bit goes 0->1.
- fall_out  output  NUM_CH  one-cycle pulse when lvl_out bit goes 1->0.
- tamper  output  1  sticky tamper indication.
- glitch_cnt  output  $clog2(TAMPER_LIMIT+1)  rejected glitches in current window, saturating at TAMPER_LIMIT.

Behaviour:
- Reset (rst high at a clock edge):
  - Synchronizer flops, debounce counters, lvl_out, rise_out, fall_out, tamper, glitch_cnt and window counter all go to 0.
  - Reset wins over every other event.
  - Reset mid-debounce discards any partial count.
- Synchronizer: 2-flop chain per channel, s1 <= raw_in, s2 <= s1.
- Debounce, per channel, with cnt of width $clog2(DEBOUNCE_CYCLES):
  - If s2 == lvl: cnt <= 0.
  - If s2 != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
- Latency: a raw change held stable appears on lvl_out exactly DEBOUNCE_CYCLES+2 rising edges after it is first sampled.
- Glitch rejection: a synchronized excursion shorter than DEBOUNCE_CYCLES cycles never changes lvl_out.
- Glitch event: any cycle where s2 returns to equal lvl while cnt != 0 (i.e. an excursion was aborted).
- Edge pulses:
  - rise_out and fall_out are registered and asserted in the same cycle lvl_out changes.
  - Each is high for exactly 1 cycle; never both high on the same channel.
- Window counter:
  - Free-running 0..WINDOW_CYCLES-1, wraps to 0.
  - On the wrap cycle glitch_cnt <= 0, but glitch events in that same cycle are counted into the new window.
- Glitch counting:
  - Each cycle glitch_cnt <= min(glitch_cnt + popcount(glitch events), TAMPER_LIMIT).
  - Multiple channels glitching in one cycle add together.
- Tamper flag:
  - Sets the cycle after glitch_cnt reaches TAMPER_LIMIT.
  - Sticky across window wraps.
- clr_tamper: tamper <= 0 and glitch_cnt <= 0.
  - Clear wins over a simultaneous set or increment.
  - Does not reset the window counter or the debounce state.
- No combinational paths from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package sensor_pkg holds:
  - channel index constants CH_ARM=0, CH_INTRUSION=1, CH_CONFIRM=2;
  - default DEBOUNCE_CYCLES, WINDOW_CYCLES and TAMPER_LIMIT values.
- One sub-module is natural: debounce_channel (synchronizer + counter + level + rise/fall + glitch strobe), instantiated NUM_CH times by a generate loop.
- Window counter and tamper logic stay in the top level.

Test Plan:
- Reset: hold rst 3 cycles with raw_in=3'b111 -> all outputs 0 during reset; lvl_out=3'b111 exactly 6 edges after rst deasserts.
- Clean edge: raw_in[0] 0->1 held -> lvl_out[0]=1 and rise_out[0]=1 on edge 6 after the change; rise_out[0]=0 next cycle; release -> fall_out[0] one-cycle pulse 6 edges later.
- Glitch: raw_in[1] high for 2 cycles then low -> lvl_out stays 0, no pulses, glitch_cnt increments by 1.
- Tamper: 8 separate 2-cycle glitches on raw_in[1] within one window -> glitch_cnt=8, tamper=1 next cycle; 3 simultaneous glitches on all channels add 3.
- Window wrap: 7 glitches, then wait past the window boundary -> glitch_cnt=0 and tamper stays 0; when tamper is already 1, it survives the wrap.
- Clear/reset priority: clr_tamper asserted in the same cycle tamper would set -> tamper=0, glitch_cnt=0; rst asserted mid-debounce (cnt=2) -> lvl_out unchanged at 0, cnt=0.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared constants for the sensor conditioning front end.
// Channel indices and default timing/threshold values.
package sensor_pkg;

   localparam int CH_ARM       = 0;
   localparam int CH_INTRUSION = 1;
   localparam int CH_CONFIRM   = 2;

   localparam int NUM_CH_DEF   = 3;
   localparam int DEBOUNCE_DEF = 4;
   localparam int WINDOW_DEF   = 1024;
   localparam int TAMPER_DEF   = 8;

endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// One sensor line: 2-flop synchronizer, debouncer, edge pulses, glitch strobe.
// Ports: clk, rst (sync, active-high), raw in; lvl, rise, fall, glitch out.
module debounce_channel
   import sensor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic lvl,
   output logic rise,
   output logic fall,
   output logic glitch
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         lvl  <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == lvl) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            lvl  <= s2;
            cnt  <= '0;
            rise <= s2;
            fall <= ~s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // An excursion that was in progress collapsed back to the held level.
   assign glitch = (s2 == lvl) && (cnt != '0);

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: per-channel debounce plus windowed glitch/tamper monitor.
// Ports: clk, rst, raw_in, clr_tamper in; lvl_out, rise_out, fall_out, tamper, glitch_cnt out.
module sensor_conditioner
   import sensor_pkg::*;
#(
   parameter int NUM_CH          = NUM_CH_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int WINDOW_CYCLES   = WINDOW_DEF,
   parameter int TAMPER_LIMIT    = TAMPER_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_CH-1:0]                 raw_in,
   input  logic                              clr_tamper,
   output logic [NUM_CH-1:0]                 lvl_out,
   output logic [NUM_CH-1:0]                 rise_out,
   output logic [NUM_CH-1:0]                 fall_out,
   output logic                              tamper,
   output logic [$clog2(TAMPER_LIMIT+1)-1:0] glitch_cnt
);

   localparam int GW = $clog2(TAMPER_LIMIT + 1);
   localparam int WW = $clog2(WINDOW_CYCLES);
   localparam int SW = GW + $clog2(NUM_CH + 1);
   localparam logic [WW-1:0] WRAP = WW'(WINDOW_CYCLES - 1);
   localparam logic [SW-1:0] LIM_S = SW'(TAMPER_LIMIT);
   localparam logic [GW-1:0] LIM_G = GW'(TAMPER_LIMIT);

   logic [NUM_CH-1:0] glitch;
   logic [WW-1:0]     wcnt;
   logic              wrap;
   logic [SW-1:0]     pop;
   logic [SW-1:0]     sum;
   logic [GW-1:0]     gc_next;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst    (rst),
         .raw    (raw_in[i]),
         .lvl    (lvl_out[i]),
         .rise   (rise_out[i]),
         .fall   (fall_out[i]),
         .glitch (glitch[i])
      );
   end

   assign wrap = (wcnt == WRAP);

   // On the wrap cycle the old window is dropped but this cycle's
   // glitches still land in the new window.
   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop = pop + SW'(glitch[i]);
      end
      sum     = (wrap ? '0 : SW'(glitch_cnt)) + pop;
      gc_next = (sum > LIM_S) ? LIM_G : sum[GW-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt       <= '0;
         glitch_cnt <= '0;
         tamper     <= 1'b0;
      end else begin
         wcnt <= wrap ? '0 : wcnt + 1'b1;
         if (clr_tamper) begin
            glitch_cnt <= '0;
            tamper     <= 1'b0;
         end else begin
            glitch_cnt <= gc_next;
            if (glitch_cnt == LIM_G) tamper <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner.
// Vector table, directed corner cases and random stimulus vs a history model.
module tb_sensor_conditioner;
   import sensor_pkg::*;

   localparam int D = 4;
   localparam int W = 1024;
   localparam int L = 8;
   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic         clr_tamper;
   logic [N-1:0] raw_in;
   logic [N-1:0] lvl_out;
   logic [N-1:0] rise_out;
   logic [N-1:0] fall_out;
   logic         tamper;
   logic [3:0]   glitch_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sensor_conditioner dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .clr_tamper (clr_tamper),
      .lvl_out    (lvl_out),
      .rise_out   (rise_out),
      .fall_out   (fall_out),
      .tamper     (tamper),
      .glitch_cnt (glitch_cnt)
   );

   // Reference: a level flips once the last D synchronized samples all
   // disagree with it; a glitch is a disagreeing run that ends early.
   logic [N-1:0] m_p1, m_p2, m_lvl, m_rise, m_fall;
   logic [N-1:0] m_hist [D];
   int           m_w, m_gc;
   logic         m_tamp;

   task automatic model(input logic r, input logic [N-1:0] x,
                        input logic cl);
      logic [N-1:0] seen, prev, flip, gl;
      int base, pop;
      if (r) begin
         m_p1 = '0; m_p2 = '0; m_lvl = '0;
         m_rise = '0; m_fall = '0;
         for (int i = 0; i < D; i++) m_hist[i] = '0;
         m_w = 0; m_gc = 0; m_tamp = 1'b0;
      end else begin
         seen = m_p2;
         m_p2 = m_p1;
         m_p1 = x;
         prev = m_hist[D-1];
         for (int i = 0; i < D-1; i++) m_hist[i] = m_hist[i+1];
         m_hist[D-1] = seen;
         for (int c = 0; c < N; c++) begin
            flip[c] = 1'b1;
            for (int i = 0; i < D; i++)
               if (m_hist[i][c] == m_lvl[c]) flip[c] = 1'b0;
            gl[c] = (seen[c] == m_lvl[c]) && (prev[c] != m_lvl[c]);
         end
         m_rise = flip & ~m_lvl;
         m_fall = flip & m_lvl;
         m_lvl  = m_lvl ^ flip;
         pop  = $countones(gl);
         base = (m_w == W-1) ? 0 : m_gc;
         if (cl) begin
            m_tamp = 1'b0;
            m_gc   = 0;
         end else begin
            if (m_gc == L) m_tamp = 1'b1;
            m_gc = (base + pop > L) ? L : base + pop;
         end
         m_w = (m_w + 1) % W;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] x,
                       input logic cl);
      rst = r; raw_in = x; clr_tamper = cl;
      @(posedge clk);
      model(r, x, cl);
      #1;
      chk("model", {lvl_out, rise_out, fall_out, tamper, glitch_cnt},
          {m_lvl, m_rise, m_fall, m_tamp, 4'(m_gc)});
   endtask

   task automatic glitch(input logic [N-1:0] mask);
      step(1'b0, mask, 1'b0);
      step(1'b0, mask, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0);
   endtask

   typedef struct {
      logic         r;
      logic [N-1:0] raw;
      logic [N-1:0] lvl;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst = 1'b1; raw_in = '0; clr_tamper = 1'b0;

      repeat (3) tbl.push_back('{1'b1, 3'b111, 3'b000, 3'b000, 3'b000});
      repeat (5) tbl.push_back('{1'b0, 3'b111, 3'b000, 3'b000, 3'b000});
      tbl.push_back('{1'b0, 3'b111, 3'b111, 3'b111, 3'b000});
      tbl.push_back('{1'b0, 3'b111, 3'b111, 3'b000, 3'b000});
      repeat (5) tbl.push_back('{1'b0, 3'b110, 3'b111, 3'b000, 3'b000});
      tbl.push_back('{1'b0, 3'b110, 3'b110, 3'b000, 3'b001});
      tbl.push_back('{1'b0, 3'b110, 3'b110, 3'b000, 3'b000});

      foreach (tbl[k]) begin
         step(tbl[k].r, tbl[k].raw, 1'b0);
         chk($sformatf("tbl%0d_lvl", k), lvl_out, tbl[k].lvl);
         chk($sformatf("tbl%0d_rise", k), rise_out, tbl[k].rise);
         chk($sformatf("tbl%0d_fall", k), fall_out, tbl[k].fall);
         chk($sformatf("tbl%0d_gc", k), {tamper, glitch_cnt}, 0);
      end

      // single glitch, then saturate to tamper
      step(1'b1, '0, 1'b0);
      glitch(3'b010);
      chk("glitch_cnt1", glitch_cnt, 1);
      chk("glitch_lvl", lvl_out, 0);
      repeat (7) glitch(3'b010);
      chk("tamper_cnt8", glitch_cnt, 8);
      chk("tamper_not_yet", tamper, 0);
      step(1'b0, '0, 1'b0);
      chk("tamper_set", tamper, 1);

      // three channels glitching together
      step(1'b1, '0, 1'b0);
      glitch(3'b111);
      chk("simul_cnt3", glitch_cnt, 3);

      // clear beats the tamper set
      step(1'b1, '0, 1'b0);
      repeat (8) glitch(3'b001);
      chk("clr_pre_cnt", glitch_cnt, 8);
      step(1'b0, '0, 1'b1);
      chk("clr_tamper", tamper, 0);
      chk("clr_cnt", glitch_cnt, 0);
      step(1'b0, '0, 1'b0);
      chk("clr_tamper_hold", tamper, 0);

      // reset mid-debounce discards the partial count
      step(1'b1, '0, 1'b0);
      repeat (4) step(1'b0, 3'b001, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      chk("rstmid_lvl", lvl_out, 0);
      repeat (5) step(1'b0, 3'b001, 1'b0);
      chk("rstmid_lvl5", lvl_out, 0);
      step(1'b0, 3'b001, 1'b0);
      chk("rstmid_lvl6", lvl_out, 3'b001);
      chk("rstmid_rise6", rise_out, 3'b001);

      // window wrap drops the count but not a set tamper
      step(1'b1, '0, 1'b0);
      repeat (7) glitch(3'b100);
      chk("win_cnt7", glitch_cnt, 7);
      repeat (1030 - 35) step(1'b0, '0, 1'b0);
      chk("win_cnt_wrap", glitch_cnt, 0);
      chk("win_no_tamper", tamper, 0);
      repeat (8) glitch(3'b100);
      step(1'b0, '0, 1'b0);
      chk("win_tamper", tamper, 1);
      repeat (2060 - 1071) step(1'b0, '0, 1'b0);
      chk("win_tamper_sticky", tamper, 1);
      chk("win_cnt_wrap2", glitch_cnt, 0);

      // random stimulus against the model
      step(1'b1, '0, 1'b0);
      begin
         logic [N-1:0] x;
         x = '0;
         for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++)
               if ($urandom_range(0, 4) == 0) x[c] = ~x[c];
            step($urandom_range(0, 1499) == 0, x,
                 $urandom_range(0, 199) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
